// File: rtl/qix_pkg.sv
// Shared types and constants for the Qix shared-RAM arbiter.
package qix_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  // Cycles from the sampling edge through the ack cycle, and the back-to-back service period.
  localparam int ACCESS_LATENCY = 3;

endpackage

// File: rtl/qix_sram_sp.sv
// Single-port synchronous RAM, write-first, one cycle read latency.
// Contents are never cleared; only the output register is reset.
module qix_sram_sp #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
  end

  // Output holds between accesses so the shared read bus stays stable until the next DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (en) begin
      dout <= we ? din : mem[addr];
    end
  end

endmodule

// File: rtl/qix_shared_ram_arb.sv
// N-port arbiter for the Qix shared RAM with built-in storage (IDLE -> ACCESS -> DONE per access).
// Define QIX_SRAM_HS_EN to add the lowest-priority hiscore back-door port.
module qix_shared_ram_arb
  import qix_pkg::*;
#(
  parameter int        NUM_PORTS = 2,
  parameter int        ADDR_W    = 11,
  parameter int        DATA_W    = 8,
  parameter arb_mode_t ARB_MODE  = ARB_FIXED,
  localparam int       ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk_20m,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
`ifdef QIX_SRAM_HS_EN
  input  logic                        hs_req,
  input  logic                        hs_we,
  input  logic [ADDR_W-1:0]           hs_address,
  input  logic [DATA_W-1:0]           hs_data_in,
  output logic [DATA_W-1:0]           hs_data_out,
  output logic                        hs_ack,
`endif
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [ID_W-1:0]             grant_id
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              hs_win;
  logic              cpu_done;
  int                rr_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] ram_dout;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign any_req = |req;

`ifdef QIX_SRAM_HS_EN
  logic hs_sel;
  assign hs_win      = hs_req & ~any_req;
  assign cpu_done    = (state == ACCESS) && !hs_sel;
  assign hs_data_out = ram_dout;
`else
  assign hs_win   = 1'b0;
  assign cpu_done = (state == ACCESS);
`endif

  // Loops run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner = '0;
    rr_idx = 0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[ID_W'(i)]) begin
          winner = ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        rr_idx = int'(last) + k;
        if (rr_idx >= NUM_PORTS) begin
          rr_idx = rr_idx - NUM_PORTS;
        end
        if (req[ID_W'(rr_idx)]) begin
          winner = ID_W'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req || hs_win) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture happens only in IDLE; later input changes cannot disturb the access.
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      grant_id  <= '0;
      last      <= ID_W'(NUM_PORTS - 1);
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant_id  <= winner;
        last      <= winner;
        lat_addr  <= addr_arr[winner];
        lat_wdata <= wdata_arr[winner];
        lat_we    <= we[winner];
`ifdef QIX_SRAM_HS_EN
      end else if (hs_req) begin
        lat_addr  <= hs_address;
        lat_wdata <= hs_data_in;
        lat_we    <= hs_we;
`endif
      end
    end
  end

`ifdef QIX_SRAM_HS_EN
  // The hiscore grant leaves grant_id and the round-robin pointer untouched.
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      hs_sel <= 1'b0;
      hs_ack <= 1'b0;
    end else begin
      hs_ack <= (state == ACCESS) && hs_sel;
      if (state == IDLE) begin
        hs_sel <= hs_win;
      end
    end
  end
`endif

  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      ack <= '0;
    end else if (cpu_done) begin
      ack <= NUM_PORTS'(1) << grant_id;
    end else begin
      ack <= '0;
    end
  end

  qix_sram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk_20m),
    .reset_n (reset_n),
    .en      (state == ACCESS),
    .we      (lat_we),
    .addr    (lat_addr),
    .din     (lat_wdata),
    .dout    (ram_dout)
  );

  assign rdata = ram_dout;

endmodule
